// File: rtl/fp_sum_ctrl.sv
// ----------------------------------------------------------------------------
// fp_sum_ctrl
//   Job sequencer for the 16-input FP adder tree with feedback accumulator.
//   A job (mode, beat count, FP32 bias) is accepted in IDLE. Beats are then
//   admitted one at a time. Each admitted beat pushes a token into a
//   fixed-latency token pipe. The pipe drives the accumulator save strobe and
//   decides when the tree result is registered and returned on sum_data.
//   Operand data never passes through this block; only the tree controls do.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   job_start            start request, sampled only in IDLE
//   job_mode             0: one sum per beat, 1: accumulate all beats onto bias
//   job_beats            beats in the job (0 ignores the start)
//   job_bias             FP32 start value loaded into the accumulator (mode 1)
//   job_abort            kill the running job
//   job_busy             high from accepted start until back in IDLE
//   job_done             1-cycle pulse with the final sum_valid of a job
//   beat_valid/ready     beat handshake for the operands on the tree inputs
//   tree_*               control outputs to the adder tree / accumulator
//   tree_result          result_all from the tree
//   sum_valid            1-cycle pulse, sum_data holds a new result
//   sum_data             registered result, held until the next sum_valid
//   sum_last             marks the final sum of a job
//   fsm_state            current sequencer state, for observation
//
// Handshake: a beat transfers on a rising edge where beat_valid && beat_ready
//   are both high in the preceding cycle. beat_ready never depends on
//   beat_valid, and the requester must hold the operands stable until the
//   transfer happens.
// ----------------------------------------------------------------------------
module fp_sum_ctrl #(
    parameter int ADD_LAT = 1,
    parameter int BEAT_W  = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              job_start,
    input  logic              job_mode,
    input  logic [BEAT_W-1:0] job_beats,
    input  logic [31:0]       job_bias,
    input  logic              job_abort,
    output logic              job_busy,
    output logic              job_done,
    input  logic              beat_valid,
    output logic              beat_ready,
    output logic              tree_clock_en,
    output logic              tree_acc_sign,
    output logic              tree_save_sign,
    output logic              tree_en_custom_last,
    output logic [31:0]       tree_custom_last,
    input  logic [31:0]       tree_result,
    output logic              sum_valid,
    output logic [31:0]       sum_data,
    output logic              sum_last,
    output logic [1:0]        fsm_state
);

    // Token index k is the token's position in cycle c+1+k, where c is the
    // accept cycle.
    localparam int SAVE_IDX = 5 * ADD_LAT - 1;  // accumulator save, cycle c+5L
    localparam int CAP0_IDX = 4 * ADD_LAT;      // mode 0 capture, cycle c+4L+1
    localparam int CAP1_IDX = 5 * ADD_LAT;      // mode 1 capture, cycle c+5L+1
    localparam int PIPE_LEN = CAP1_IDX + 1;
    localparam int GAP_W    = $clog2(ADD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q;
    logic [BEAT_W-1:0]   rem_q;
    logic [31:0]         bias_q;
    logic [GAP_W-1:0]    gap_q;
    logic [PIPE_LEN-1:0] tok_v_q, tok_v_d;
    logic [PIPE_LEN-1:0] tok_last_q, tok_last_d;
    logic                sum_valid_q, sum_last_q;
    logic [31:0]         sum_data_q;

    logic start_ok;
    logic abort_now;
    logic accept;
    logic last_beat;
    logic capture;
    logic capture_last;

    assign start_ok  = job_start && (job_beats != '0);
    assign abort_now = job_abort && (state_q != S_IDLE);
    assign last_beat = (rem_q == BEAT_W'(1));

    // gap_q blocks the next mode-1 beat until the accumulator feedback
    // has consumed the previous one.
    assign beat_ready = (state_q == S_RUN) && (rem_q != '0) && (gap_q == '0) && !job_abort;
    assign accept     = beat_valid && beat_ready;

    // Mode 1 only returns the final token; intermediate ones just save.
    assign capture      = mode_q ? (tok_v_q[CAP1_IDX] && tok_last_q[CAP1_IDX]) : tok_v_q[CAP0_IDX];
    assign capture_last = mode_q ? 1'b1 : tok_last_q[CAP0_IDX];

    // Next-state and token-pipe logic.
    always_comb begin
        state_d    = state_q;
        tok_v_d    = {tok_v_q[PIPE_LEN-2:0], accept};
        tok_last_d = {tok_last_q[PIPE_LEN-2:0], accept && last_beat};

        // Mode 0 tokens retire at their capture point so DRAIN ends on time.
        if (!mode_q) begin
            tok_v_d[CAP0_IDX+1]    = 1'b0;
            tok_last_d[CAP0_IDX+1] = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = job_mode ? S_LOAD : S_RUN;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (accept && last_beat) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tok_v_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_now) begin
            state_d    = S_IDLE;
            tok_v_d    = '0;
            tok_last_d = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            rem_q       <= '0;
            bias_q      <= '0;
            gap_q       <= '0;
            tok_v_q     <= '0;
            tok_last_q  <= '0;
            sum_valid_q <= 1'b0;
            sum_last_q  <= 1'b0;
            sum_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tok_v_q    <= tok_v_d;
            tok_last_q <= tok_last_d;

            if ((state_q == S_IDLE) && start_ok) begin
                mode_q <= job_mode;
                rem_q  <= job_beats;
                bias_q <= job_bias;
            end else if (abort_now) begin
                rem_q <= '0;
            end else if (accept) begin
                rem_q <= rem_q - BEAT_W'(1);
            end

            if (abort_now) begin
                gap_q <= '0;
            end else if (accept && mode_q) begin
                gap_q <= GAP_W'(ADD_LAT);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - GAP_W'(1);
            end

            sum_valid_q <= capture && !abort_now;
            sum_last_q  <= capture && capture_last && !abort_now;
            if (capture && !abort_now) begin
                sum_data_q <= tree_result;
            end
        end
    end

    assign fsm_state           = state_q;
    assign job_busy            = (state_q != S_IDLE);
    assign tree_clock_en       = (state_q != S_IDLE);
    assign tree_acc_sign       = mode_q && (state_q != S_IDLE);
    assign tree_en_custom_last = (state_q == S_LOAD);
    assign tree_custom_last    = (state_q == S_LOAD) ? bias_q : 32'h0;
    assign tree_save_sign      = (state_q == S_LOAD)
                               || ((state_q != S_IDLE) && mode_q && tok_v_q[SAVE_IDX]);

    assign sum_valid = sum_valid_q;
    assign sum_data  = sum_data_q;
    assign sum_last  = sum_last_q;
    // A final sum that coincides with an abort is still delivered, but the
    // job is not reported as done.
    assign job_done  = sum_last_q && !job_abort;

endmodule

// File: tb/tb_fp_sum_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fp_sum_ctrl
//   Bench for fp_sum_ctrl with ADD_LAT = 1. It contains a cycle-level model of
//   the adder tree and accumulator that responds to the DUT controls. The tree
//   model uses integer-valued operands, so every FP32 value here is exact.
//   Expected sums come from a job-level model of the results:
//     mode 0: one sum per beat, at accept + 6;
//     mode 1: bias + all beats, at last accept + 7.
// ----------------------------------------------------------------------------
module tb_fp_sum_ctrl;

    localparam int BEAT_W = 8;

    logic              aclk;
    logic              aresetn;
    logic              job_start;
    logic              job_mode;
    logic [BEAT_W-1:0] job_beats;
    logic [31:0]       job_bias;
    logic              job_abort;
    logic              job_busy;
    logic              job_done;
    logic              beat_valid;
    logic              beat_ready;
    logic              tree_clock_en;
    logic              tree_acc_sign;
    logic              tree_save_sign;
    logic              tree_en_custom_last;
    logic [31:0]       tree_custom_last;
    logic [31:0]       tree_result;
    logic              sum_valid;
    logic [31:0]       sum_data;
    logic              sum_last;
    logic [1:0]        fsm_state;

    fp_sum_ctrl #(.ADD_LAT(1), .BEAT_W(BEAT_W)) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .job_start           (job_start),
        .job_mode            (job_mode),
        .job_beats           (job_beats),
        .job_bias            (job_bias),
        .job_abort           (job_abort),
        .job_busy            (job_busy),
        .job_done            (job_done),
        .beat_valid          (beat_valid),
        .beat_ready          (beat_ready),
        .tree_clock_en       (tree_clock_en),
        .tree_acc_sign       (tree_acc_sign),
        .tree_save_sign      (tree_save_sign),
        .tree_en_custom_last (tree_en_custom_last),
        .tree_custom_last    (tree_custom_last),
        .tree_result         (tree_result),
        .sum_valid           (sum_valid),
        .sum_data            (sum_data),
        .sum_last            (sum_last),
        .fsm_state           (fsm_state)
    );

    // ---------------- clock / reset / bookkeeping ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached with %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- FP32 helpers (integer values only) ----------------
    function automatic logic [31:0] int_to_fp(input int v);
        int          p;
        logic [31:0] m;
        if (v <= 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 31; i++) if (v[i]) p = i;
        m = 32'(v) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic int fp_to_int(input logic [31:0] f);
        int          e;
        logic [31:0] m;
        e = int'(f[30:23]);
        if (e == 0) return 0;
        m = {8'h0, 1'b1, f[22:0]};
        if (e >= 150) return int'(m << (e - 150));
        return int'(m >> (150 - e));
    endfunction

    // ---------------- adder tree + accumulator model ----------------
    int ops[16];
    int ops_total;
    int tp[4];
    int res0;
    int add_out;
    int acc;

    always_comb begin
        ops_total = 0;
        for (int i = 0; i < 16; i++) ops_total += ops[i];
    end

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 4; i++) tp[i] <= 0;
            res0    <= 0;
            add_out <= 0;
            acc     <= 0;
        end else if (tree_clock_en) begin
            tp[0]   <= ops_total;
            tp[1]   <= tp[0];
            tp[2]   <= tp[1];
            tp[3]   <= tp[2];
            res0    <= tp[3];
            add_out <= acc + tp[3];
            if (tree_save_sign)
                acc <= tree_en_custom_last ? fp_to_int(tree_custom_last) : add_out;
        end
    end

    always_comb tree_result = tree_acc_sign ? int_to_fp(acc) : int_to_fp(res0);

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          save_cnt  = 0;
    int          sum_cnt   = 0;
    logic [31:0] last_data = 32'h0;
    bit          prev_done = 1'b0;

    always @(negedge aclk) begin
        #2;
        if (aresetn) begin
            if (prev_done) chk("busy_drop_after_done", 32'(job_busy), 0);
            prev_done = job_done;
            if (tree_save_sign) save_cnt++;
            if (sum_valid) begin
                sum_cnt++;
                last_data = sum_data;
                if (exp_q.size() == 0) begin
                    chk("unexpected_sum_valid", 32'(sum_valid), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sum_data", sum_data, mon_e.data);
                    chk("sum_cycle", cyc, mon_e.cyc);
                    chk("sum_last", 32'(sum_last), 32'(mon_e.last));
                    chk("job_done", 32'(job_done), 32'(mon_e.last && !job_abort));
                end
            end
        end else begin
            prev_done = 1'b0;
        end
    end

    // ---------------- driver ----------------
    bit cur_mode;
    int cur_bias;
    int beats_left;
    int total;
    int n_acc;
    int first_acc;
    int last_acc;

    task automatic garbage_ops();
        for (int i = 0; i < 16; i++) ops[i] = $urandom_range(0, 1000);
    endtask

    task automatic start_job(input bit mode, input int beats, input logic [31:0] bias);
        cur_mode   = mode;
        cur_bias   = fp_to_int(bias);
        beats_left = beats;
        total      = 0;
        n_acc      = 0;
        job_start  = 1'b1;
        job_mode   = mode;
        job_beats  = BEAT_W'(beats);
        job_bias   = bias;
        @(negedge aclk);
        job_start  = 1'b0;
        chk("busy_after_start", 32'(job_busy), 1);
    endtask

    task automatic record_accept(input int s);
        if (cur_mode && n_acc > 0) chk("mode1_issue_gap", (cyc - last_acc >= 2) ? 1 : 0, 1);
        if (n_acc == 0) first_acc = cyc;
        last_acc = cyc;
        n_acc++;
        beats_left--;
        if (!cur_mode) begin
            exp_q.push_back('{cyc + 6, int_to_fp(s), beats_left == 0});
        end else begin
            total += s;
            if (beats_left == 0) exp_q.push_back('{cyc + 7, int_to_fp(cur_bias + total), 1'b1});
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_beat(input int gap, input bit rnd, input int opval);
        int s;
        int t;
        for (int g = 0; g < gap; g++) begin
            beat_valid = 1'b0;
            garbage_ops();
            @(negedge aclk);
        end
        s = 0;
        for (int i = 0; i < 16; i++) begin
            ops[i] = rnd ? int'($urandom_range(0, 15)) : opval;
            s += ops[i];
        end
        beat_valid = 1'b1;
        t = 0;
        #1;
        while (!beat_ready && t < 50) begin
            @(negedge aclk);
            #1;
            t++;
        end
        if (!beat_ready) begin
            chk("beat_accept_timeout", 32'(beat_ready), 1);
            beat_valid = 1'b0;
            @(negedge aclk);
            return;
        end
        record_accept(s);
        @(negedge aclk);
        beat_valid = 1'b0;
        garbage_ops();
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (job_busy && t < 300) begin
            @(negedge aclk);
            t++;
        end
        if (job_busy) chk({name, "_idle_timeout"}, 32'(job_busy), 0);
        repeat (3) @(negedge aclk);
        chk({name, "_all_sums_seen"}, exp_q.size(), 0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctrl_outputs"},
            32'({job_busy, job_done, beat_ready, tree_clock_en, tree_acc_sign, tree_save_sign,
                 tree_en_custom_last, sum_valid, sum_last, fsm_state}), 0);
        chk({name, "_custom_last"}, tree_custom_last, 0);
        chk({name, "_sum_data"}, sum_data, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          mode;
        int          beats;
        logic [31:0] bias;
        int          opval;      // -1: every operand of beat b is b+1
        int          max_gap;
        logic [31:0] exp_last;
        int          exp_sums;
        int          exp_saves;
    } vec_t;

    vec_t vecs[5];
    int   sum_base;
    int   save_base;
    int   target;
    int   tw;
    int   nb;

    initial begin
        vecs[0] = '{1'b1, 3, 32'h3F800000,  1, 0, 32'h42440000, 1, 4};  // 1 + 48 = 49
        vecs[1] = '{1'b0, 4, 32'h00000000, -1, 0, 32'h42800000, 4, 0};  // 16,32,48,64
        vecs[2] = '{1'b0, 1, 32'h00000000,  2, 0, 32'h42000000, 1, 0};  // 32
        vecs[3] = '{1'b1, 2, 32'h41200000,  3, 0, 32'h42D40000, 1, 3};  // 10 + 96 = 106
        vecs[4] = '{1'b1, 1, 32'h00000000,  1, 0, 32'h41800000, 1, 2};  // 16

        aresetn    = 1'b0;
        job_start  = 1'b0;
        job_mode   = 1'b0;
        job_beats  = '0;
        job_bias   = '0;
        job_abort  = 1'b0;
        beat_valid = 1'b0;
        garbage_ops();
        repeat (3) @(negedge aclk);
        chk_zero("reset");
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // Table-driven jobs (T1, T2 and extra patterns).
        for (int v = 0; v < 5; v++) begin
            sum_base  = sum_cnt;
            save_base = save_cnt;
            start_job(vecs[v].mode, vecs[v].beats, vecs[v].bias);
            for (int b = 0; b < vecs[v].beats; b++)
                send_beat(vecs[v].max_gap, 1'b0, (vecs[v].opval < 0) ? b + 1 : vecs[v].opval);
            wait_idle("vec");
            chk("vec_last_data", last_data, vecs[v].exp_last);
            chk("vec_sum_count", sum_cnt - sum_base, vecs[v].exp_sums);
            chk("vec_save_count", save_cnt - save_base, vecs[v].exp_saves);
            chk("vec_accept_span", last_acc - first_acc, (vecs[v].beats - 1) * (vecs[v].mode ? 2 : 1));
        end

        // T3: zero-beat start is ignored; a start during RUN changes nothing.
        job_start = 1'b1;
        job_mode  = 1'b0;
        job_beats = '0;
        @(negedge aclk);
        job_start = 1'b0;
        chk("zero_beats_busy", 32'(job_busy), 0);
        sum_base = sum_cnt;
        start_job(1'b0, 3, 32'h0);
        send_beat(0, 1'b0, 2);
        job_start = 1'b1;
        job_mode  = 1'b1;
        job_beats = BEAT_W'(9);
        job_bias  = 32'h3F800000;
        @(negedge aclk);
        job_start = 1'b0;
        chk("restart_state_run", 32'(fsm_state), 2);
        chk("restart_acc_sign", 32'(tree_acc_sign), 0);
        send_beat(0, 1'b0, 3);
        send_beat(0, 1'b0, 4);
        wait_idle("restart");
        chk("restart_sum_count", sum_cnt - sum_base, 3);

        // T4: abort in RUN after 1 of 3 beats, then a fresh mode-1 job.
        sum_base = sum_cnt;
        start_job(1'b1, 3, 32'h3F800000);
        send_beat(0, 1'b0, 1);
        @(negedge aclk);
        job_abort  = 1'b1;
        beat_valid = 1'b1;
        #1;
        chk("abort_ready_low", 32'(beat_ready), 0);
        @(negedge aclk);
        job_abort  = 1'b0;
        beat_valid = 1'b0;
        chk("abort_busy", 32'(job_busy), 0);
        chk("abort_clock_en", 32'(tree_clock_en), 0);
        repeat (12) @(negedge aclk);
        chk("abort_no_sum", sum_cnt - sum_base, 0);
        save_base = save_cnt;
        start_job(1'b1, 1, 32'h0);
        send_beat(0, 1'b0, 1);
        wait_idle("after_abort");
        chk("after_abort_data", last_data, 32'h41800000);
        chk("after_abort_saves", save_cnt - save_base, 2);

        // Abort in the same cycle as the final sum_valid.
        start_job(1'b0, 1, 32'h0);
        send_beat(0, 1'b0, 5);
        target = last_acc + 6;
        tw = 0;
        while (cyc != target && tw < 20) begin
            @(negedge aclk);
            tw++;
        end
        job_abort = 1'b1;
        #1;
        chk("abort_final_valid", 32'(sum_valid), 1);
        chk("abort_final_done", 32'(job_done), 0);
        @(negedge aclk);
        job_abort = 1'b0;
        chk("abort_final_busy", 32'(job_busy), 0);
        wait_idle("abort_final");

        // T5: reset pulse while draining.
        sum_base = sum_cnt;
        start_job(1'b0, 2, 32'h0);
        send_beat(0, 1'b0, 3);
        send_beat(0, 1'b0, 3);
        @(negedge aclk);
        chk("drain_state", 32'(fsm_state), 3);
        #3;
        aresetn = 1'b0;
        exp_q.delete();
        #1;
        chk_zero("mid_reset");
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (15) @(negedge aclk);
        chk("reset_no_sum", sum_cnt - sum_base, 0);
        chk("reset_clock_en", 32'(tree_clock_en), 0);

        // T6: random mode-1 jobs with random beat gaps, then random mode-0 jobs.
        for (int j = 0; j < 3; j++) begin
            sum_base  = sum_cnt;
            save_base = save_cnt;
            start_job(1'b1, 4, int_to_fp(int'($urandom_range(0, 200))));
            for (int b = 0; b < 4; b++) send_beat($urandom_range(0, 5), 1'b1, 0);
            wait_idle("rand_m1");
            chk("rand_m1_saves", save_cnt - save_base, 5);
            chk("rand_m1_sums", sum_cnt - sum_base, 1);
        end
        for (int j = 0; j < 3; j++) begin
            sum_base = sum_cnt;
            nb = $urandom_range(1, 6);
            start_job(1'b0, nb, 32'h0);
            for (int b = 0; b < nb; b++) send_beat($urandom_range(0, 2), 1'b1, 0);
            wait_idle("rand_m0");
            chk("rand_m0_sums", sum_cnt - sum_base, nb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
